// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: repeats a captured MSB-first serial pattern rep_cnt+1 times back-to-back.
// Defining SEQ_GEN_PARITY_EN appends an even-parity bit after every pass.
module seq_pattern_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [3:0]       pat_len,
  input  logic [3:0]       rep_cnt,
  output logic             out_seq,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
  logic par_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state_q;
  logic [WIDTH-1:0] pat_q, sh_q, aligned;
  logic [3:0] len_q, idx_q, rep_q, pass_q, len_eff;
  // Pattern is left-aligned at capture so the first bit is always at WIDTH-1 and unused bits drop out.
  always_comb begin
    len_eff = (pat_len == 4'd0 || pat_len > 4'(WIDTH)) ? 4'(WIDTH) : pat_len;
    aligned = pat_data << (4'(WIDTH) - len_eff);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      pass_q    <= '0;
      out_seq   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      done <= 1'b0;
      if (start) begin
        state_q   <= SHIFT;
        pat_q     <= aligned;
        sh_q      <= aligned << 1;
        len_q     <= len_eff;
        idx_q     <= len_eff - 4'd1;
        rep_q     <= rep_cnt;
        pass_q    <= '0;
        out_seq   <= aligned[WIDTH-1];
        out_valid <= 1'b1;
        busy      <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
        par_q     <= ^aligned;
`endif
      end
    end else if (state_q == DONE) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else if (state_q == SHIFT && idx_q != 4'd0) begin
      out_seq <= sh_q[WIDTH-1];
      sh_q    <= sh_q << 1;
      idx_q   <= idx_q - 4'd1;
`ifdef SEQ_GEN_PARITY_EN
    end else if (state_q == SHIFT) begin
      state_q <= PAR;
      out_seq <= par_q;
`endif
    end else if (pass_q == rep_q) begin
      state_q   <= DONE;
      done      <= 1'b1;
      out_seq   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q <= SHIFT;
      pass_q  <= pass_q + 4'd1;
      out_seq <= pat_q[WIDTH-1];
      sh_q    <= pat_q << 1;
      idx_q   <= len_q - 4'd1;
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: reference-model and directed-vector bench for seq_pattern_gen.
module tb_seq_pattern_gen;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start, out_seq, out_valid, busy, done;
  logic [W-1:0] pat_data;
  logic [3:0] pat_len, rep_cnt;
  int vec = 0, miss = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b0000;
  logic [31:0] stream;
  int nbits, hits, dones;

  seq_pattern_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_data(pat_data), .pat_len(pat_len),
    .rep_cnt(rep_cnt), .out_seq(out_seq), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: on a start seen while idle, lay out the whole transmission as a list of {seq,valid,busy,done}.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur = 4'b0000;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (cur == 4'b0000 && start) begin
      int len;
      logic p;
      len = (pat_len == 0 || pat_len > W) ? W : int'(pat_len);
      for (int r = 0; r <= int'(rep_cnt); r++) begin
        p = 1'b0;
        for (int i = len - 1; i >= 0; i--) begin
          exp_q.push_back({pat_data[i], 3'b110});
          p ^= pat_data[i];
        end
`ifdef SEQ_GEN_PARITY_EN
        exp_q.push_back({p, 3'b110});
`endif
      end
      exp_q.push_back(4'b0001);
      cur = exp_q.pop_front();
    end else begin
      cur = 4'b0000;
    end
  end

  always @(negedge clk) begin
    check("outputs", {out_seq, out_valid, busy, done}, cur);
    if (out_valid) begin
      stream = {stream[30:0], out_seq};
      nbits++;
      if (nbits >= 5 && stream[4:0] == 5'b10110) hits++;
    end
    if (done) dones++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stream = '0;
    nbits = 0;
    hits = 0;
    dones = 0;
  endtask

  task automatic run(input logic [W-1:0] pd, input logic [3:0] len, input logic [3:0] rep, input int n);
    pat_data = pd;
    pat_len = len;
    rep_cnt = rep;
    clr();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(n);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pat_data = '0;
    pat_len = '0;
    rep_cnt = '0;
    clr();
    cyc(2);
    check("reset_outputs", {out_seq, out_valid, busy, done}, 4'b0000);
    rst = 1'b0;
    cyc(2);

    run(8'b0001_0110, 4'd5, 4'd1, 16);
`ifdef SEQ_GEN_PARITY_EN
    check("pat10110_x2_stream", stream[11:0], 12'b101101_101101);
    check("pat10110_x2_bits", nbits, 12);
`else
    check("pat10110_x2_stream", stream[9:0], 10'b10110_10110);
    check("pat10110_x2_bits", nbits, 10);
`endif
    check("pat10110_x2_detect", hits, 2);
    check("pat10110_x2_done", dones, 1);

    run(8'hA5, 4'd0, 4'd0, 12);
`ifdef SEQ_GEN_PARITY_EN
    check("len0_stream", stream[8:0], 9'b10100101_0);
`else
    check("len0_stream", stream[7:0], 8'b10100101);
    check("len0_bits", nbits, 8);
`endif

    run(8'h3C, 4'd9, 4'd0, 12);
`ifndef SEQ_GEN_PARITY_EN
    check("len9_clamp_stream", stream[7:0], 8'b00111100);
`endif
    check("len9_clamp_done", dones, 1);

    run(8'h01, 4'd1, 4'd2, 8);
`ifdef SEQ_GEN_PARITY_EN
    check("len1_stream", stream[5:0], 6'b11_11_11);
`else
    check("len1_stream", stream[2:0], 3'b111);
`endif

    run(8'h02, 4'd2, 4'd15, 52);
`ifdef SEQ_GEN_PARITY_EN
    check("rep15_bits", nbits, 48);
`else
    check("rep15_stream", stream, 32'hAAAA_AAAA);
    check("rep15_bits", nbits, 32);
`endif
    check("rep15_done", dones, 1);

    pat_data = 8'b0001_0110;
    pat_len = 4'd5;
    rep_cnt = 4'd0;
    clr();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    start = 1'b1;
    pat_data = 8'hFF;
    pat_len = 4'd8;
    rep_cnt = 4'd3;
    cyc(1);
    start = 1'b0;
    cyc(8);
`ifdef SEQ_GEN_PARITY_EN
    check("midstart_stream", stream[5:0], 6'b10110_1);
`else
    check("midstart_stream", stream[4:0], 5'b10110);
    check("midstart_bits", nbits, 5);
`endif
    check("midstart_done", dones, 1);

    pat_data = 8'b0001_0110;
    pat_len = 4'd5;
    rep_cnt = 4'd0;
    clr();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("abort_third_bit", {out_seq, out_valid, busy}, 3'b111);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("abort_outputs", {out_seq, out_valid, busy, done}, 4'b0000);
    cyc(8);
    check("abort_no_done", dones, 0);

    rst = 1'b1;
    start = 1'b1;
    cyc(1);
    rst = 1'b0;
    start = 1'b0;
    cyc(3);
    check("rst_start_ignored", {out_valid, busy}, 2'b00);

    run(8'b0001_0110, 4'd5, 4'd0, 8);
    check("post_abort_detect", hits, 1);
    check("post_abort_done", dones, 1);

    pat_data = 8'b0000_0101;
    pat_len = 4'd3;
    rep_cnt = 4'd0;
    clr();
    start = 1'b1;
    cyc(7);
    start = 1'b0;
    cyc(8);
`ifdef SEQ_GEN_PARITY_EN
    check("held_start_stream", stream[7:0], 8'b1010_1010);
`else
    check("held_start_stream", stream[5:0], 6'b101_101);
`endif
    check("held_start_done", dones, 2);

    check("model_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter: WIDTH, default 8, maximum pattern length in bits (legal 2..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 pat_data  input  WIDTH  pattern; bits [pat_len-1:0] used, sent MSB (bit pat_len-1) first.
REQ-006 pat_len  input  4  pattern length in bits.
REQ-007 rep_cnt  input  4  repetition count minus one (0 = one pass, 15 = sixteen passes).
REQ-008 out_seq  output  1  registered serial bit stream, one bit per clk.
REQ-009 out_valid  output  1  registered; high while out_seq carries a pattern or parity bit.
REQ-010 busy  output  1  registered; high from the first transmitted bit through the last.
REQ-011 done  output  1  registered one-cycle pulse after the last bit.

Function
REQ-012 FSM states: IDLE, SHIFT, PAR (present only with the macro), DONE.
REQ-013 IDLE: out_valid=0, out_seq=0, busy=0; start=1 at an edge captures pat_data, pat_len and rep_cnt into internal registers and enters SHIFT.
REQ-014 Latency: the first bit (pat_data[pat_len-1]) appears on out_seq the cycle after the capturing edge, with out_valid=1 and busy=1.
REQ-015 SHIFT: one bit per cycle, descending index; the bit counter reloads at the end of each pass, and the next pass begins with no idle gap.
REQ-016 Total pattern bits = L*(rep_cnt+1), where L is the effective length (REQ-019).
REQ-017 Passes are back-to-back, so an overlapping serial detector on out_seq sees every occurrence across pass boundaries.
REQ-018 After the final bit (or parity bit), enter DONE for exactly one cycle: done=1, out_valid=0, busy=0, out_seq=0; then return to IDLE.
REQ-019 pat_len=0 or pat_len>WIDTH is clamped to L=WIDTH; pat_len=1 is legal (L=1).
REQ-020 Captured values are stable for the whole transmission; changes on pat_data, pat_len or rep_cnt while busy=1 have no effect.
REQ-021 start while busy=1 or in DONE is ignored, not queued; start held high continuously yields one DONE cycle between transmissions.
REQ-022 Repetition counter width 4; the counter never wraps, and transmission stops after exactly rep_cnt+1 passes.

Reset
REQ-023 rst=1 at an edge forces IDLE, out_seq=0, out_valid=0, busy=0, done=0, and clears all counters and the captured pattern.
REQ-024 Reset has priority over start and aborts a transmission in progress at that edge; no done pulse is produced.
REQ-025 When rst and start are both high at the same edge, start is ignored.

Configuration
REQ-026 Macro SEQ_GEN_PARITY_EN: when defined, one even-parity bit (XOR of the L pattern bits) is sent in state PAR after each pass, with out_valid=1, before the next pass or DONE.
REQ-027 With SEQ_GEN_PARITY_EN defined, total valid bits = (L+1)*(rep_cnt+1).
REQ-028 When SEQ_GEN_PARITY_EN is undefined, the PAR state and parity logic are absent and REQ-016 timing applies.

Verification
REQ-029 pat_data=8'b0001_0110, pat_len=5, rep_cnt=1, start pulse -> out_seq 1,0,1,1,0,1,0,1,1,0 on 10 consecutive cycles with out_valid=1, then done=1 for one cycle; an overlapping 10110 detector fires twice.
REQ-030 pat_len=0, pat_data=8'hA5, rep_cnt=0 -> 8 bits 1,0,1,0,0,1,0,1, then done.
REQ-031 start pulsed mid-transmission and pat_data changed to 8'hFF -> stream unchanged, single done pulse.
REQ-032 rst=1 on the 3rd bit of a 5-bit transmission -> next cycle: all outputs 0, state IDLE, no done pulse; a fresh start then transmits normally.
REQ-033 With SEQ_GEN_PARITY_EN defined: 10110, len 5, rep_cnt=0 -> 1,0,1,1,0,1 (parity 1), then done.
REQ-034 start held high, len 3, pattern 3'b101, rep_cnt=0 -> 1,0,1, done, then 1,0,1 again.
